// File: rtl/ncc_pkg.sv
// Shared types and constants for the NCC candidate scheduler.
package ncc_pkg;

    localparam int NUM_PIXELS_DEF = 256;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_DESC = 3'd1,
        ST_LOAD_WIN  = 3'd2,
        ST_COMPUTE   = 3'd3,
        ST_FINISH    = 3'd4
    } state_e;

    typedef logic [31:0] score_t;

    // Requests above the legal maximum run as the maximum.
    function automatic logic [7:0] clamp_cand(input logic [7:0] n, input int unsigned max_cand);
        if (32'(n) > max_cand) begin
            return max_cand[7:0];
        end
        return n;
    endfunction

endpackage

// File: rtl/ncc_byte_counter.sv
// Byte counter for one descriptor/window phase. Counts accepted bytes
// 0..NUM_PIXELS-1; tc flags the last byte of the phase, and an enabled
// count at tc wraps back to zero ready for the next phase.
module ncc_byte_counter
    import ncc_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    localparam int CW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          tc
);

    assign tc = (count == CW'(NUM_PIXELS - 1));

    // Clear wins over enable; terminal count wraps to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (tc) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ncc_sched.sv
// NCC job scheduler: streams one descriptor then num_cand candidate windows
// into the shift registers, fires the correlation engine after each window
// and collects its scores.
// Optional best-score tracking is built when NCC_SCHED_BEST_TRACK_EN is
// defined; otherwise best_idx/best_score are constant zero.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   IDLE      | waiting for start
//   LOAD_DESC | accepting NUM_PIXELS descriptor bytes
//   LOAD_WIN  | accepting NUM_PIXELS bytes of the current window
//   COMPUTE   | engine running on current window, wait for eng_done
//   FINISH    | one-cycle done pulse, then back to IDLE
module ncc_sched
    import ncc_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int MAX_CAND   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pciIn,
    input  logic       pci_valid,
    output logic       pci_ready,
    input  logic       start,
    input  logic [7:0] num_cand,
    output logic       desc_load,
    output logic       desc_shift,
    output logic       win_load,
    output logic       win_shift,
    output logic [7:0] data_out,
    output logic       eng_start,
    input  logic       eng_done,
    input  score_t     eng_score,
    output logic       busy,
    output logic       done,
    output logic [7:0] best_idx,
    output score_t     best_score
);

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_LOAD_DESC = ST_LOAD_DESC;
    localparam logic [2:0] S_LOAD_WIN  = ST_LOAD_WIN;
    localparam logic [2:0] S_COMPUTE   = ST_COMPUTE;
    localparam logic [2:0] S_FINISH    = ST_FINISH;
    localparam int         CW          = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [7:0]    num_cand_q;
    logic [7:0]    cand_cnt;
    logic [CW-1:0] byte_cnt;
    logic          byte_tc;
    logic          accept;
    logic          byte_first;
    logic          job_go;
    logic          capture;
    logic          cand_last;

    assign pci_ready  = (state == S_LOAD_DESC) || (state == S_LOAD_WIN);
    assign accept     = pci_valid && pci_ready;
    assign data_out   = pciIn;
    assign byte_first = (byte_cnt == '0);

    assign desc_load  = accept && (state == S_LOAD_DESC) && byte_first;
    assign desc_shift = accept && (state == S_LOAD_DESC) && !byte_first;
    assign win_load   = accept && (state == S_LOAD_WIN) && byte_first;
    assign win_shift  = accept && (state == S_LOAD_WIN) && !byte_first;

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FINISH);

    assign job_go     = (state == S_IDLE) && start;
    assign capture    = (state == S_COMPUTE) && eng_done;
    assign cand_last  = (({1'b0, cand_cnt} + 9'd1) == {1'b0, num_cand_q});

    ncc_byte_counter #(
        .NUM_PIXELS (NUM_PIXELS)
    ) u_byte_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .clr   (job_go),
        .count (byte_cnt),
        .tc    (byte_tc)
    );

    // Next-state decode for the job sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD_DESC;
            end
            S_LOAD_DESC: begin
                if (accept && byte_tc) begin
                    state_nxt = (num_cand_q != 8'd0) ? S_LOAD_WIN : S_FINISH;
                end
            end
            S_LOAD_WIN: begin
                if (accept && byte_tc) state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (eng_done) state_nxt = cand_last ? S_FINISH : S_LOAD_WIN;
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; eng_start is registered so it covers exactly the
    // first COMPUTE cycle after each window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            eng_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            eng_start <= (state == S_LOAD_WIN) && (state_nxt == S_COMPUTE);
        end
    end

    // Job size latch and candidate counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_cand_q <= 8'd0;
            cand_cnt   <= 8'd0;
        end else if (job_go) begin
            num_cand_q <= clamp_cand(num_cand, MAX_CAND);
            cand_cnt   <= 8'd0;
        end else if (capture) begin
            cand_cnt   <= cand_cnt + 8'd1;
        end
    end

`ifdef NCC_SCHED_BEST_TRACK_EN
    score_t     best_score_q;
    logic [7:0] best_idx_q;

    // Running maximum; first score always taken, ties keep the lower index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_score_q <= '0;
            best_idx_q   <= 8'd0;
        end else if (job_go) begin
            best_score_q <= '0;
            best_idx_q   <= 8'd0;
        end else if (capture && ((cand_cnt == 8'd0) || (eng_score > best_score_q))) begin
            best_score_q <= eng_score;
            best_idx_q   <= cand_cnt;
        end
    end

    assign best_score = best_score_q;
    assign best_idx   = best_idx_q;
`else
    logic unused_score;

    assign unused_score = ^eng_score;
    assign best_score   = '0;
    assign best_idx     = 8'd0;
`endif

endmodule

// File: tb/tb_ncc_sched.sv
// Randomized scoreboard bench for ncc_sched (NUM_PIXELS=4, MAX_CAND=6).
module tb_ncc_sched;
    import ncc_pkg::*;

    localparam int NP = 4;
    localparam int MC = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pciIn = 8'd0;
    logic       pci_valid = 1'b0;
    logic       pci_ready;
    logic       start = 1'b0;
    logic [7:0] num_cand = 8'd0;
    logic       desc_load, desc_shift, win_load, win_shift;
    logic [7:0] data_out;
    logic       eng_start;
    logic       eng_done = 1'b0;
    score_t     eng_score = '0;
    logic       busy, done;
    logic [7:0] best_idx;
    score_t     best_score;

    ncc_sched #(.NUM_PIXELS(NP), .MAX_CAND(MC)) dut (
        .clk        (clk),
        .rst        (rst),
        .pciIn      (pciIn),
        .pci_valid  (pci_valid),
        .pci_ready  (pci_ready),
        .start      (start),
        .num_cand   (num_cand),
        .desc_load  (desc_load),
        .desc_shift (desc_shift),
        .win_load   (win_load),
        .win_shift  (win_shift),
        .data_out   (data_out),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .eng_score  (eng_score),
        .busy       (busy),
        .done       (done),
        .best_idx   (best_idx),
        .best_score (best_score)
    );

    typedef struct {
        int         nc;
        logic [7:0] bidx;
        score_t     bscore;
    } job_t;

    job_t       job_q[$];
    logic [3:0] byte_q[$];
    score_t     score_q[$];
    score_t     given[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vmode = 0;
    bit stray_en = 1'b0;
    int last_acc = 0;
    int last_fire = 0;
    int n_es = 0;
    bit prev_es = 1'b0;
    int ed = 0;
    bit pend = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
        end
    endtask

    function automatic score_t rand_score();
        if ($urandom_range(0, 3) == 0) return score_t'($urandom);
        return score_t'($urandom_range(0, 5) * 16);
    endfunction

    // Byte source: valid pattern chosen by vmode (0 steady, 1 toggle, 2 random).
    always @(posedge clk) begin
        #1;
        case (vmode)
            0:       pci_valid = 1'b1;
            1:       pci_valid = ~pci_valid;
            default: pci_valid = 1'($urandom_range(0, 1));
        endcase
        pciIn = 8'($urandom);
    end

    task automatic fire();
        eng_done  = 1'b1;
        eng_score = (score_q.size() != 0) ? score_q.pop_front() : score_t'(0);
        last_fire = cyc;
    endtask

    // Engine model: answers each eng_start after 0..3 cycles; optionally
    // injects stray eng_done pulses while bytes are being loaded.
    always @(posedge clk) begin
        #1;
        eng_done = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (eng_start) begin
            ed = $urandom_range(0, 3);
            if (ed == 0) fire();
            else pend = 1'b1;
        end else if (pend) begin
            ed--;
            if (ed == 0) begin
                fire();
                pend = 1'b0;
            end
        end else if (stray_en && pci_ready && ($urandom_range(0, 3) == 0)) begin
            eng_done  = 1'b1;
            eng_score = 32'hFFFF_FFFF;
        end
    end

    // Monitor: pops expected strobes per accepted byte and job results on done.
    always @(negedge clk) begin
        logic [3:0] strb;
        logic [3:0] eb;
        job_t       j;
        int         exp_cyc;
        if (rst) begin
            n_es    = 0;
            prev_es = 1'b0;
        end else begin
            strb = {desc_load, desc_shift, win_load, win_shift};
            if (pci_valid && pci_ready) begin
                chk("data_out", 64'(data_out), 64'(pciIn));
                if (byte_q.size() == 0) begin
                    chk("extra_byte_strobe", 64'(strb), 64'(0));
                    chk("extra_byte_accept", 64'(1), 64'(0));
                end else begin
                    eb = byte_q.pop_front();
                    chk("byte_strobe", 64'(strb), 64'(eb));
                end
                last_acc = cyc;
            end else begin
                chk("idle_strobe", 64'(strb), 64'(0));
            end
            if (eng_start) begin
                chk("eng_start_width", 64'(prev_es), 64'(0));
                n_es++;
            end
            prev_es = eng_start;
            if (done) begin
                if (job_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'(0));
                end else begin
                    j = job_q.pop_front();
                    exp_cyc = (j.nc == 0) ? last_acc + 1 : last_fire + 1;
                    chk("done_cycle", 64'(cyc), 64'(exp_cyc));
                    chk("eng_start_count", 64'(n_es), 64'(j.nc));
                    chk("bytes_left", 64'(byte_q.size()), 64'(0));
                    chk("best_idx", 64'(best_idx), 64'(j.bidx));
                    chk("best_score", 64'(best_score), 64'(j.bscore));
                    chk("busy_at_done", 64'(busy), 64'(1));
                end
                n_es = 0;
            end
        end
    end

    // Reference model: expected strobe sequence and best result for a job.
    task automatic prepare(input int nc_in, input bit use_given);
        int     nce;
        score_t sc[$];
        job_t   j;
        nce = (nc_in > MC) ? MC : nc_in;
        if (use_given) sc = given;
        else for (int i = 0; i < nce; i++) sc.push_back(rand_score());
        j.nc     = nce;
        j.bidx   = 8'd0;
        j.bscore = '0;
`ifdef NCC_SCHED_BEST_TRACK_EN
        for (int i = 0; i < nce; i++) begin
            if (i == 0 || sc[i] > j.bscore) begin
                j.bscore = sc[i];
                j.bidx   = 8'(i);
            end
        end
`endif
        for (int i = 0; i < nce; i++) score_q.push_back(sc[i]);
        for (int p = 0; p < NP; p++) byte_q.push_back((p == 0) ? 4'b1000 : 4'b0100);
        for (int c = 0; c < nce; c++)
            for (int p = 0; p < NP; p++) byte_q.push_back((p == 0) ? 4'b0010 : 4'b0001);
        job_q.push_back(j);
    endtask

    task automatic flush();
        byte_q.delete();
        job_q.delete();
        score_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        flush();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic start_job(input int nc_in, input bit hold);
        @(posedge clk); #1;
        start    = 1'b1;
        num_cand = 8'(nc_in);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        else num_cand = 8'(nc_in) ^ 8'h05;
    endtask

    task automatic wait_done(input bit hold);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        if (hold) start = 1'b0;
        chk("job_finished", 64'(seen), 64'(1));
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'(0));
        if (!seen) do_reset();
    endtask

    task automatic run(input int nc_in, input bit hold, input bit stray, input bit use_given);
        stray_en = stray;
        prepare(nc_in, use_given);
        start_job(nc_in, hold);
        wait_done(hold);
        stray_en = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pci_ready", 64'(pci_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_strobes", 64'({desc_load, desc_shift, win_load, win_shift}), 64'(0));
        chk("rst_eng_start", 64'(eng_start), 64'(0));
        chk("rst_best_idx", 64'(best_idx), 64'(0));
        chk("rst_best_score", 64'(best_score), 64'(0));
        chk("rst_data_out", 64'(data_out), 64'(pciIn));
        rst = 1'b0;

        vmode = 0;
        run(0, 1'b0, 1'b0, 1'b0);

        given = '{32'd10, 32'd30, 32'd30};
        run(3, 1'b0, 1'b0, 1'b1);

        vmode = 1;
        run(2, 1'b0, 1'b0, 1'b0);

        vmode = 0;
        run(2, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of the first window load.
        prepare(2, 1'b0);
        start_job(2, 1'b0);
        n = 0;
        while (byte_q.size() > 6 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_load_win", 64'(byte_q.size() <= 6), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_pci_ready", 64'(pci_ready), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_eng_start", 64'(eng_start), 64'(0));
        flush();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_busy", 64'(busy), 64'(0));
        chk("postrst_pci_ready", 64'(pci_ready), 64'(0));
        run(3, 1'b0, 1'b0, 1'b0);

        run(9, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            vmode = $urandom_range(0, 2);
            run($urandom_range(0, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ncc_sched.md
NCC_SCHED -- requirements
Module: ncc_sched

Interface
REQ-001 Parameter NUM_PIXELS, default 256, bytes per descriptor and per candidate window.
REQ-002 Parameter MAX_CAND, default 255, largest legal candidate count.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pciIn  input  8  pixel byte stream.
REQ-006 pci_valid / pci_ready  input / output  1 each  byte handshake; a byte is accepted when both are high on a posedge.
REQ-007 start  input  1  begin a job; num_cand  input  8  candidate windows in the job.
REQ-008 desc_load, desc_shift  output  1 each  descriptor shift-register controls.
REQ-009 win_load, win_shift  output  1 each  window shift-register controls.
REQ-010 data_out  output  8  byte forwarded to both registers.
REQ-011 eng_start  output  1, eng_done  input  1, eng_score  input  32  correlation engine handshake.
REQ-012 busy, done  output  1 each; best_idx  output  8; best_score  output  32.

Function
REQ-013 FSM states: IDLE, LOAD_DESC, LOAD_WIN, COMPUTE, FINISH.
REQ-014 IDLE: start=1 latches num_cand, clears byte and candidate counters, and moves to LOAD_DESC; start is ignored in every other state.
REQ-015 pci_ready=1 only in LOAD_DESC and LOAD_WIN; data_out=pciIn combinationally.
REQ-016 LOAD_DESC: the first accepted byte pulses desc_load, each later accepted byte pulses desc_shift, and no strobe is asserted in a cycle without acceptance.
REQ-017 LOAD_WIN: same rule as REQ-016 using win_load/win_shift.
REQ-018 Byte counter increments per accepted byte; the NUM_PIXELS-th acceptance clears it and exits the state on the next edge.
REQ-019 LOAD_DESC exit: to LOAD_WIN if latched num_cand>0, else FINISH.
REQ-020 LOAD_WIN exit: to COMPUTE; eng_start is high for exactly the first cycle in COMPUTE.
REQ-021 COMPUTE: on eng_done=1, capture eng_score; candidate counter increments; next state FINISH if the counter reaches num_cand, else LOAD_WIN.
REQ-022 eng_done outside COMPUTE is ignored; eng_done in the same cycle as eng_start is honoured.
REQ-023 FINISH lasts one cycle, done=1 there, then IDLE; busy=1 in every state except IDLE.
REQ-024 Latency: min job = NUM_PIXELS*(1+num_cand) accepted bytes + per-candidate engine time + 1 FINISH cycle.
REQ-025 num_cand>MAX_CAND is clamped to MAX_CAND.

Reset
REQ-026 rst=1 forces IDLE at once, even mid-job, and clears all counters.
REQ-027 Reset values: pci_ready, all strobes, eng_start, busy, done = 0; data_out follows pciIn; best_idx=0, best_score=0.

Configuration
REQ-028 Macro NCC_SCHED_BEST_TRACK_EN.
REQ-029 Macro defined: start clears best_idx and best_score, and the first captured score is always taken.
REQ-030 Macro defined: later scores replace the held values only if strictly greater unsigned, so ties keep the lower index.
REQ-031 Macro defined: best_idx = 0-based candidate index; best_score, best_idx hold after done until the next start.
REQ-032 Macro undefined: best_idx and best_score are tied to 0 and no comparator is built; all other behaviour is unchanged.

Structure
REQ-033 Package ncc_pkg holds the state enum typedef, a score_t (32-bit unsigned) typedef, and the default NUM_PIXELS constant.
REQ-034 One sub-module ncc_byte_counter (enable, clear, terminal-count flag) is instantiated for byte counting; the candidate counter is inline.

Verification
REQ-035 NUM_PIXELS=4, num_cand=0, bytes 1..4 continuous valid -> desc_load on byte 1, desc_shift on bytes 2-4, done one cycle after 4th accept, no eng_start.
REQ-036 num_cand=3, scores 10, 30, 30 -> best_idx=1, best_score=30 at done; three eng_start pulses, 12 window bytes accepted.
REQ-037 pci_valid toggled 1/0 each cycle -> strobes only on accepted cycles; byte count per phase exactly NUM_PIXELS.
REQ-038 rst asserted mid LOAD_WIN -> next cycle IDLE, pci_ready=0, busy=0; new start runs a full job correctly.
REQ-039 start held high during a job and eng_done pulsed in LOAD_WIN -> both ignored; the job completes with the original num_cand.
REQ-040 Build without NCC_SCHED_BEST_TRACK_EN, rerun REQ-036 -> identical handshakes, best_idx=0, best_score=0.
